psk_symbol_unpack: RTL and testbench

PSK_SYMBOL_UNPACK -- requirements
Module: psk_symbol_unpack

---
 rtl/psk_pkg.sv | 15 +
 rtl/psk_symbol_unpack.sv | 117 +++++++++++
 tb/tb_psk_symbol_unpack.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psk_pkg.sv
// Shared definitions for the PSK symbol unpacker: FSM state encoding and per-byte symbol counts.
// Latency: none, this file holds only types and constants.
// Backpressure: not applicable; imported by psk_symbol_unpack.
package psk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } psk_state_t;

   localparam int BPSK_SYMS_PER_BYTE = 8;
   localparam int QPSK_SYMS_PER_BYTE = 4;

endpackage

// File: rtl/psk_symbol_unpack.sv
// Unpacks AXIS words into one BPSK/QPSK symbol per output beat; PSK_UNPACK_LSB_FIRST_EN selects LSB-first order.
// Latency: first symbol one cycle after the input handshake; following words of a packet load with no bubble.
// Backpressure: m_tready stalls the symbol counter; s_tready opens in IDLE or on the last symbol of a non-final word.
module psk_symbol_unpack
   import psk_pkg::*;
#(
   parameter int IN_BYTES  = 1,
   parameter int OUT_BYTES = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [IN_BYTES*8-1:0]  s_tdata,
   input  logic                   s_tvalid,
   input  logic                   s_tlast,
   input  logic                   s_tuser,
   output logic                   s_tready,
   output logic [OUT_BYTES*8-1:0] m_tdata,
   output logic                   m_tvalid,
   output logic                   m_tlast,
   output logic                   m_tuser,
   input  logic                   m_tready
);

   localparam int W  = IN_BYTES * 8;
   localparam int CW = $clog2(8 * IN_BYTES);
   localparam logic [CW-1:0] LAST_B = CW'(BPSK_SYMS_PER_BYTE * IN_BYTES - 1);
   localparam logic [CW-1:0] LAST_Q = CW'(QPSK_SYMS_PER_BYTE * IN_BYTES - 1);

   psk_state_t    state;
   psk_state_t    state_nxt;
   logic [W-1:0]  sreg;        // current word, shifted so the next symbol sits at the read end
   logic [W-1:0]  sreg_shift;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   logic [CW-1:0] last_idx;
   logic          word_last;   // word was latched with s_tlast
   logic          mid_pkt;     // first-word flag: 0 means the next accepted word opens a packet
   logic          accept;
   logic          advance;
   logic          last_sym;
   logic [1:0]    sym;

   // Handshake qualifiers, input ready and next-state selection.
   always_comb begin
      last_idx  = m_tuser ? LAST_B : LAST_Q;
      last_sym  = (cnt == last_idx);
      cnt_inc   = cnt + CW'(1);
      advance   = m_tvalid & m_tready;
      s_tready  = 1'b0;
      state_nxt = state;
      if (!rst) begin
         case (state)
            IDLE:    s_tready = 1'b1;
            SHIFT:   s_tready = advance & last_sym & ~word_last;
            default: s_tready = 1'b0;
         endcase
      end
      accept = s_tvalid & s_tready;
      case (state)
         IDLE: begin
            if (accept) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (advance && last_sym) begin
               if (word_last)   state_nxt = GAP;
               else if (accept) state_nxt = SHIFT;
               else             state_nxt = IDLE;
            end
         end
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Symbol extraction from the read end of the shifter; only bits [1:0] ever carry data.
   always_comb begin
`ifdef PSK_UNPACK_LSB_FIRST_EN
      sym        = m_tuser ? {sreg[0], 1'b0} : sreg[1:0];
      sreg_shift = m_tuser ? (sreg >> 1) : (sreg >> 2);
`else
      sym        = m_tuser ? {sreg[W-1], 1'b0} : sreg[W-1 -: 2];
      sreg_shift = m_tuser ? (sreg << 1) : (sreg << 2);
`endif
      m_tdata      = '0;
      m_tdata[1:0] = sym;
   end

   // State, word shifter, symbol counter and the registered output flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sreg      <= '0;
         cnt       <= '0;
         word_last <= 1'b0;
         mid_pkt   <= 1'b0;
         m_tvalid  <= 1'b0;
         m_tlast   <= 1'b0;
         m_tuser   <= 1'b0;
      end else begin
         state    <= state_nxt;
         m_tvalid <= (state_nxt == SHIFT);
         if (accept) begin
            sreg      <= s_tdata;
            cnt       <= '0;
            word_last <= s_tlast;
            m_tlast   <= 1'b0;   // a word always carries at least four symbols
            mid_pkt   <= ~s_tlast;
            if (!mid_pkt) m_tuser <= s_tuser;
         end else if (advance) begin
            sreg    <= sreg_shift;
            cnt     <= cnt_inc;
            m_tlast <= word_last & ~last_sym & (cnt_inc == last_idx);
         end
      end
   end

endmodule

// File: tb/tb_psk_symbol_unpack.sv
// Self-checking bench for psk_symbol_unpack: directed packets with literal symbol sequences plus random traffic.
// Latency: a reference queue of expected beats is built from each input handshake and drained on each output handshake.
// Backpressure: m_tready driven always-on, toggling or random; stalled outputs are checked for stability.
module tb_psk_symbol_unpack;

   localparam int IN_BYTES  = 1;
   localparam int OUT_BYTES = 1;
   localparam int W         = IN_BYTES * 8;

   typedef struct {
      logic [OUT_BYTES*8-1:0] d;
      logic                   l;
      logic                   u;
      int                     cyc;
   } beat_t;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [W-1:0]           s_tdata;
   logic                   s_tvalid;
   logic                   s_tlast;
   logic                   s_tuser;
   logic                   s_tready;
   logic [OUT_BYTES*8-1:0] m_tdata;
   logic                   m_tvalid;
   logic                   m_tlast;
   logic                   m_tuser;
   logic                   m_tready;

   int    checks = 0;
   int    passes = 0;
   int    rdy_mode = 0;
   int    nbeats = 0;
   int    nlast = 0;
   int    cyc = 0;
   int    exp_d[8];
   beat_t exp_q[$];
   beat_t cap[$];

   // reference-model packet state
   logic  mdl_open = 1'b0;
   logic  mdl_mode = 1'b0;

   // previous-cycle observations used by the compare process
   logic                   p_acc = 0, p_stall = 0, p_lasths = 0, p2_lasths = 0;
   logic [OUT_BYTES*8-1:0] p_d = '0;
   logic                   p_l = 0, p_u = 0;

   psk_symbol_unpack #(.IN_BYTES(IN_BYTES), .OUT_BYTES(OUT_BYTES)) dut (
      .clk      (clk),
      .rst      (rst),
      .s_tdata  (s_tdata),
      .s_tvalid (s_tvalid),
      .s_tlast  (s_tlast),
      .s_tuser  (s_tuser),
      .s_tready (s_tready),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tlast  (m_tlast),
      .m_tuser  (m_tuser),
      .m_tready (m_tready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      else passes++;
   endtask

   // downstream ready pattern: 0 = always ready, 1 = toggle, 2 = random
   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // compare process: reference queue plus per-cycle protocol checks
   always @(negedge clk) begin : mon
      beat_t b;
      beat_t e;
      int    nsym;
      int    k;
      logic  acc;
      logic  ohs;
      cyc++;
      if (rst) begin
         exp_q.delete();
         mdl_open  = 1'b0;
         p_acc     = 0;
         p_stall   = 0;
         p_lasths  = 0;
         p2_lasths = 0;
      end else begin
         if (p_acc) chk("latency1", m_tvalid, 1);
         if (p_stall) chk("stall_hold", {m_tvalid, m_tlast, m_tuser, m_tdata}, {1'b1, p_l, p_u, p_d});
         if (p_lasths) begin
            chk("gap_valid", m_tvalid, 0);
            chk("gap_ready", s_tready, 0);
         end
         if (p2_lasths) chk("idle_ready", s_tready, 1);
         acc = s_tvalid & s_tready;
         ohs = m_tvalid & m_tready;
         if (ohs) begin
            b.d = m_tdata; b.l = m_tlast; b.u = m_tuser; b.cyc = cyc;
            cap.push_back(b);
            nbeats++;
            if (m_tlast) nlast++;
            if (exp_q.size() == 0) begin
               chk("beat_expected", 0, 1);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", m_tdata, e.d);
               chk("beat_last", m_tlast, e.l);
               chk("beat_user", m_tuser, e.u);
            end
         end
         if (acc) begin
            if (!mdl_open) mdl_mode = s_tuser;
            mdl_open = !s_tlast;
            nsym = mdl_mode ? 8 * IN_BYTES : 4 * IN_BYTES;
            for (int i = 0; i < nsym; i++) begin
`ifdef PSK_UNPACK_LSB_FIRST_EN
               k = i;
`else
               k = nsym - 1 - i;
`endif
               e.d = '0;
               if (mdl_mode) e.d[1] = s_tdata[k];
               else          e.d[1:0] = s_tdata[2*k +: 2];
               e.l   = s_tlast && (i == nsym - 1);
               e.u   = mdl_mode;
               e.cyc = 0;
               exp_q.push_back(e);
            end
         end
         p2_lasths = p_lasths;
         p_lasths  = ohs & m_tlast;
         p_acc     = acc;
         p_stall   = m_tvalid & ~m_tready;
         p_d = m_tdata; p_l = m_tlast; p_u = m_tuser;
      end
   end

   // present one word and hold it until accepted; s_tvalid stays high on return
   task automatic send(input logic [W-1:0] d, input logic l, input logic u);
      bit done = 0;
      s_tdata = d; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk);
         if (s_tready) done = 1;
      end
      if (!done) chk("send_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pkt(input int n0);
      bit done = 0;
      for (int n = 0; n < 300 && !done; n++) begin
         @(posedge clk);
         if (nlast > n0) done = 1;
      end
      if (!done) chk("pkt_timeout", 0, 1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_cap(input string name, input int n, input logic u);
      chk({name, "_count"}, cap.size(), n);
      for (int i = 0; i < n && i < cap.size(); i++) begin
         chk({name, "_data"}, cap[i].d, exp_d[i]);
         chk({name, "_last"}, cap[i].l, (i == n - 1));
         chk({name, "_user"}, cap[i].u, u);
      end
   endtask

   task automatic one_word(input logic [W-1:0] d, input logic u);
      int n0 = nlast;
      cap.delete();
      send(d, 1'b1, u);
      s_tvalid = 1'b0;
      wait_pkt(n0);
   endtask

   initial begin : main
      int n0;
      int b0;
      int nw;
      s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tuser = 1'b0; rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s_tready", s_tready, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tlast", m_tlast, 0);
      chk("rst_m_tuser", m_tuser, 0);
      chk("rst_m_tdata", m_tdata, 0);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk("idle_s_tready", s_tready, 1);
      @(posedge clk); #1;

      // QPSK 0xB4
`ifdef PSK_UNPACK_LSB_FIRST_EN
      exp_d = '{0, 1, 3, 2, 0, 0, 0, 0};
`else
      exp_d = '{2, 3, 1, 0, 0, 0, 0, 0};
`endif
      one_word(8'hB4, 1'b0);
      check_cap("qpsk_b4", 4, 1'b0);

      // BPSK 0xA5
      exp_d = '{2, 0, 2, 0, 0, 2, 0, 2};
      one_word(8'hA5, 1'b1);
      check_cap("bpsk_a5", 8, 1'b1);

      // QPSK two-word packet, s_tvalid held between words
`ifdef PSK_UNPACK_LSB_FIRST_EN
      exp_d = '{3, 2, 1, 0, 0, 1, 2, 3};
`else
      exp_d = '{0, 1, 2, 3, 3, 2, 1, 0};
`endif
      n0 = nlast; cap.delete();
      send(8'h1B, 1'b0, 1'b0);
      send(8'hE4, 1'b1, 1'b0);
      s_tvalid = 1'b0;
      wait_pkt(n0);
      check_cap("two_word", 8, 1'b0);
      if (cap.size() == 8) chk("two_word_contig", cap[7].cyc - cap[0].cyc, 7);

      // toggling downstream ready
      rdy_mode = 1;
`ifdef PSK_UNPACK_LSB_FIRST_EN
      exp_d = '{0, 1, 3, 2, 0, 0, 0, 0};
`else
      exp_d = '{2, 3, 1, 0, 0, 0, 0, 0};
`endif
      one_word(8'hB4, 1'b0);
      check_cap("toggle_b4", 4, 1'b0);
      rdy_mode = 0;

      // mode is taken from the first word only
      exp_d = '{0, 0, 0, 0, 3, 3, 3, 3};
      n0 = nlast; cap.delete();
      send(8'h00, 1'b0, 1'b0);
      send(8'hFF, 1'b1, 1'b1);
      s_tvalid = 1'b0;
      wait_pkt(n0);
      check_cap("mode_hold", 8, 1'b0);

      // reset pulse after the second symbol discards the word
      n0 = nlast; b0 = nbeats; cap.delete();
      send(8'hB4, 1'b1, 1'b0);
      s_tvalid = 1'b0;
      for (int n = 0; n < 50 && nbeats < b0 + 2; n++) @(posedge clk);
      #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_valid", m_tvalid, 0);
      chk("rst_mid_no_tlast", nlast, n0);
      @(posedge clk); #1;
`ifdef PSK_UNPACK_LSB_FIRST_EN
      exp_d = '{0, 1, 3, 2, 0, 0, 0, 0};
`else
      exp_d = '{2, 3, 1, 0, 0, 0, 0, 0};
`endif
      one_word(8'hB4, 1'b0);
      check_cap("post_rst_b4", 4, 1'b0);

      // random packets, random ready, random input gaps
      rdy_mode = 2;
      for (int p = 0; p < 40; p++) begin
         nw = $urandom_range(1, 3);
         for (int w = 0; w < nw; w++) begin
            send(W'($urandom), (w == nw - 1), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
               s_tvalid = 1'b0;
               repeat ($urandom_range(1, 6)) @(posedge clk);
               #1;
            end
         end
         if ($urandom_range(0, 1) == 0) begin
            s_tvalid = 1'b0;
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
         end
      end
      s_tvalid = 1'b0;
      rdy_mode = 0;
      for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(posedge clk);
      repeat (3) @(posedge clk);
      chk("drain_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", checks, passes);
      $fatal(1, "watchdog");
   end

endmodule
